// File: rtl/serial_deser.sv
// Serial link receiver: deframes start/data/parity/stop frames into bytes, packs WORDS bytes
// little-endian into one word and holds it for a valid/ack handshake.
// Error pulses (parity, framing, overrun) and byte_valid are registered, one cycle wide.
module serial_deser #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned WORDS   = 4,
   parameter int unsigned PARITY  = 1,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                    clk,
   input  logic                    nRst,
   input  logic                    rx,
   input  logic                    clear,
   input  logic                    word_ack,
   output logic [DATA_W*WORDS-1:0] word,
   output logic                    word_valid,
   output logic                    byte_valid,
   output logic                    parity_err,
   output logic                    frame_err,
   output logic                    overrun,
   output logic                    busy
);

   localparam int unsigned OUT_W = DATA_W * WORDS;
   localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      StWaitIdle,
      StIdle,
      StData,
      StPar,
      StStop
   } state_e;

   state_e              state_q, state_d;
   logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic                par_q, par_d;
   logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic [OUT_W-1:0]    partial_q, partial_d;
   logic [OUT_W-1:0]    word_q, word_d;
   logic                word_valid_q, word_valid_d;
   logic                byte_valid_q, byte_valid_d;
   logic                parity_err_q, parity_err_d;
   logic                frame_err_q, frame_err_d;
   logic                overrun_q, overrun_d;
   logic                busy_q, busy_d;

   logic [OUT_W-1:0]    assembled;
   logic                parity_ok;

   // Next-state logic for the deframer, byte packer, handshake and idle timeout.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      par_d        = par_q;
      byte_cnt_d   = byte_cnt_q;
      tmo_d        = tmo_q;
      partial_d    = partial_q;
      word_d       = word_q;
      word_valid_d = word_valid_q;
      byte_valid_d = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      overrun_d    = 1'b0;

      // Partial word with the just-received byte dropped into its slot.
      assembled = partial_q;
      assembled[byte_cnt_q*DATA_W +: DATA_W] = shift_q;

      parity_ok = (PARITY == 0) || ((^shift_q ^ par_q) == 1'b0);

      // Ack retires the held word; a completion below may reload it in the same cycle.
      if (word_valid_q && word_ack) begin
         word_valid_d = 1'b0;
      end

      unique case (state_q)
         StWaitIdle: begin
            if (rx) begin
               state_d = StIdle;
            end
         end
         StIdle: begin
            if (!rx) begin
               state_d   = StData;
               bit_cnt_d = '0;
               tmo_d     = '0;
            end else if (byte_cnt_q != '0) begin
               if (tmo_q == TMO_LAST) begin
                  byte_cnt_d = '0;
                  tmo_d      = '0;
               end else begin
                  tmo_d = tmo_q + TMO_W'(1);
               end
            end else begin
               tmo_d = '0;
            end
         end
         StData: begin
            shift_d   = {rx, shift_q[DATA_W-1:1]};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == BIT_LAST) begin
               state_d = (PARITY != 0) ? StPar : StStop;
            end
         end
         StPar: begin
            par_d   = rx;
            state_d = StStop;
         end
         StStop: begin
            if (!rx) begin
               // Framing error wins over a parity error on the same frame.
               state_d     = StWaitIdle;
               frame_err_d = 1'b1;
            end else begin
               state_d = StIdle;
               if (!parity_ok) begin
                  parity_err_d = 1'b1;
               end else begin
                  byte_valid_d = 1'b1;
                  if (byte_cnt_q == CNT_LAST) begin
                     byte_cnt_d = '0;
                     if (!word_valid_q || word_ack) begin
                        word_d       = assembled;
                        word_valid_d = 1'b1;
                     end else begin
                        overrun_d = 1'b1;
                     end
                  end else begin
                     partial_d  = assembled;
                     byte_cnt_d = byte_cnt_q + CNT_W'(1);
                  end
               end
            end
         end
         default: begin
            state_d = StWaitIdle;
         end
      endcase

      // Flush overrides completion and ack; the held word value itself is kept.
      if (clear) begin
         state_d      = StWaitIdle;
         byte_cnt_d   = '0;
         tmo_d        = '0;
         word_valid_d = 1'b0;
         byte_valid_d = 1'b0;
         parity_err_d = 1'b0;
         frame_err_d  = 1'b0;
         overrun_d    = 1'b0;
      end

      busy_d = (state_d != StIdle) || (byte_cnt_d != '0);
   end

   // State and registered outputs; nRst is a synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (nRst) begin
         state_q      <= StWaitIdle;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         par_q        <= 1'b0;
         byte_cnt_q   <= '0;
         tmo_q        <= '0;
         partial_q    <= '0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
         byte_valid_q <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         par_q        <= par_d;
         byte_cnt_q   <= byte_cnt_d;
         tmo_q        <= tmo_d;
         partial_q    <= partial_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
         byte_valid_q <= byte_valid_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
         busy_q       <= busy_d;
      end
   end

   assign word       = word_q;
   assign word_valid = word_valid_q;
   assign byte_valid = byte_valid_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_serial_deser.sv
// Directed bench for serial_deser (DATA_W=8, WORDS=4, PARITY=1, TIMEOUT=64).
// Inputs are driven on the falling edge; outputs are read on the falling edge.
module tb_serial_deser;

   logic        clk;
   logic        nRst;
   logic        rx;
   logic        clear;
   logic        word_ack;
   logic [31:0] word;
   logic        word_valid;
   logic        byte_valid;
   logic        parity_err;
   logic        frame_err;
   logic        overrun;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   // Pulse tallies, sampled on the rising edge (value before the DUT updates).
   int bv_cnt = 0;
   int pe_cnt = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;

   serial_deser #(
      .DATA_W (8),
      .WORDS  (4),
      .PARITY (1),
      .TIMEOUT(64)
   ) dut (
      .clk       (clk),
      .nRst      (nRst),
      .rx        (rx),
      .clear     (clear),
      .word_ack  (word_ack),
      .word      (word),
      .word_valid(word_valid),
      .byte_valid(byte_valid),
      .parity_err(parity_err),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (byte_valid === 1'b1) bv_cnt++;
      if (parity_err === 1'b1) pe_cnt++;
      if (frame_err === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
   end

   // Bit 0 is the start bit, bits 1..8 are data LSB-first, bit 9 parity, bit 10 stop.
   function automatic logic [10:0] make_frame(input logic [7:0] d, input logic flip,
                                              input logic stop);
      make_frame = {stop, (^d) ^ flip, d, 1'b0};
   endfunction

   // Returns on the falling edge where the stop bit was driven (not yet sampled).
   task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop,
                             input logic ack_stop);
      logic [10:0] f;
      f = make_frame(d, flip, stop);
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         rx       = f[i];
         word_ack = (i == 10) ? ack_stop : 1'b0;
      end
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear    = 1'b1;
      rx       = 1'b1;
      word_ack = 1'b0;
      @(negedge clk);
      clear = 1'b0;
      @(negedge clk);
   endtask

   task automatic ack_word();
      @(negedge clk);
      word_ack = 1'b1;
      @(negedge clk);
      word_ack = 1'b0;
   endtask

   task automatic test_reset();
      nRst     = 1'b1;
      rx       = 1'b1;
      clear    = 1'b0;
      word_ack = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({word_valid, byte_valid, parity_err, frame_err, overrun, busy} !== 6'b0) begin
         n_err++;
         $display("FAIL reset_flags: got %b want 000000",
                  {word_valid, byte_valid, parity_err, frame_err, overrun, busy});
      end
      n_cmp++;
      if (word !== 32'h0) begin
         n_err++;
         $display("FAIL reset_word: got %h want 00000000", word);
      end
      nRst = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_idle_busy: got %b want 0", busy);
      end
   endtask

   task automatic test_first_byte();
      send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (byte_valid !== 1'b0) begin
         n_err++;
         $display("FAIL latency_early: byte_valid=%b at cycle 10, want 0", byte_valid);
      end
      @(negedge clk);
      rx = 1'b1;
      n_cmp++;
      if (byte_valid !== 1'b1) begin
         n_err++;
         $display("FAIL latency_11: byte_valid=%b at cycle 11, want 1", byte_valid);
      end
      n_cmp++;
      if ({parity_err, frame_err, overrun} !== 3'b000) begin
         n_err++;
         $display("FAIL first_byte_errs: got %b want 000", {parity_err, frame_err, overrun});
      end
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL first_byte_busy: got %b want 1", busy);
      end
      @(negedge clk);
      n_cmp++;
      if (byte_valid !== 1'b0) begin
         n_err++;
         $display("FAIL byte_valid_width: got %b want 0", byte_valid);
      end
      do_clear();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL clear_busy: got %b want 0", busy);
      end
   endtask

   task automatic test_back_to_back();
      int b0;
      b0 = bv_cnt;
      send_frame(8'h11, 1'b0, 1'b1, 1'b0);
      send_frame(8'h22, 1'b0, 1'b1, 1'b0);
      send_frame(8'h33, 1'b0, 1'b1, 1'b0);
      send_frame(8'h44, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      rx = 1'b1;
      n_cmp++;
      if (word_valid !== 1'b1 || word !== 32'h44332211) begin
         n_err++;
         $display("FAIL b2b_word: valid=%b word=%h want 1 44332211", word_valid, word);
      end
      repeat (2) @(negedge clk);
      n_cmp++;
      if (word_valid !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_hold: word_valid=%b want 1", word_valid);
      end
      @(negedge clk);
      word_ack = 1'b1;
      @(negedge clk);
      word_ack = 1'b0;
      n_cmp++;
      if (word_valid !== 1'b0 || word !== 32'h44332211) begin
         n_err++;
         $display("FAIL b2b_ack: valid=%b word=%h want 0 44332211", word_valid, word);
      end
      n_cmp++;
      if (bv_cnt - b0 !== 4) begin
         n_err++;
         $display("FAIL b2b_bytes: got %0d byte pulses want 4", bv_cnt - b0);
      end
   endtask

   task automatic test_parity_err();
      int b0;
      int p0;
      b0 = bv_cnt;
      p0 = pe_cnt;
      send_frame(8'h11, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      rx = 1'b1;
      n_cmp++;
      if (parity_err !== 1'b1 || byte_valid !== 1'b0) begin
         n_err++;
         $display("FAIL parity_pulse: perr=%b bv=%b want 1 0", parity_err, byte_valid);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL parity_cnt: busy=%b want 0", busy);
      end
      send_frame(8'h11, 1'b0, 1'b1, 1'b0);
      send_frame(8'h22, 1'b0, 1'b1, 1'b0);
      send_frame(8'h33, 1'b0, 1'b1, 1'b0);
      send_frame(8'h44, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      rx = 1'b1;
      n_cmp++;
      if (word_valid !== 1'b1 || word !== 32'h44332211) begin
         n_err++;
         $display("FAIL parity_word: valid=%b word=%h want 1 44332211", word_valid, word);
      end
      ack_word();
      n_cmp++;
      if (bv_cnt - b0 !== 4 || pe_cnt - p0 !== 1) begin
         n_err++;
         $display("FAIL parity_counts: bytes=%0d perr=%0d want 4 1", bv_cnt - b0, pe_cnt - p0);
      end
   endtask

   task automatic test_frame_err();
      int b0;
      int f0;
      b0 = bv_cnt;
      f0 = fe_cnt;
      send_frame(8'h55, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rx = 1'b0;
      n_cmp++;
      if (frame_err !== 1'b1 || byte_valid !== 1'b0) begin
         n_err++;
         $display("FAIL frame_pulse: ferr=%b bv=%b want 1 0", frame_err, byte_valid);
      end
      repeat (4) @(negedge clk);
      @(negedge clk);
      rx = 1'b1;
      send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      rx = 1'b1;
      n_cmp++;
      if (byte_valid !== 1'b1) begin
         n_err++;
         $display("FAIL frame_recover: byte_valid=%b want 1", byte_valid);
      end
      @(negedge clk);
      n_cmp++;
      if (fe_cnt - f0 !== 1 || bv_cnt - b0 !== 1) begin
         n_err++;
         $display("FAIL frame_counts: ferr=%0d bytes=%0d want 1 1", fe_cnt - f0, bv_cnt - b0);
      end
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL frame_partial: busy=%b want 1", busy);
      end
      do_clear();
   endtask

   task automatic test_overrun();
      int o0;
      o0 = ov_cnt;
      send_frame(8'h01, 1'b0, 1'b1, 1'b0);
      send_frame(8'h02, 1'b0, 1'b1, 1'b0);
      send_frame(8'h03, 1'b0, 1'b1, 1'b0);
      send_frame(8'h04, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      rx = 1'b1;
      n_cmp++;
      if (word_valid !== 1'b1 || word !== 32'h04030201) begin
         n_err++;
         $display("FAIL ovr_first: valid=%b word=%h want 1 04030201", word_valid, word);
      end
      send_frame(8'hA1, 1'b0, 1'b1, 1'b0);
      send_frame(8'hA2, 1'b0, 1'b1, 1'b0);
      send_frame(8'hA3, 1'b0, 1'b1, 1'b0);
      send_frame(8'hA4, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      rx = 1'b1;
      n_cmp++;
      if (overrun !== 1'b1 || byte_valid !== 1'b1) begin
         n_err++;
         $display("FAIL ovr_pulse: overrun=%b bv=%b want 1 1", overrun, byte_valid);
      end
      n_cmp++;
      if (word_valid !== 1'b1 || word !== 32'h04030201 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL ovr_keep: valid=%b word=%h busy=%b want 1 04030201 0",
                  word_valid, word, busy);
      end
      send_frame(8'hB1, 1'b0, 1'b1, 1'b0);
      send_frame(8'hB2, 1'b0, 1'b1, 1'b0);
      send_frame(8'hB3, 1'b0, 1'b1, 1'b0);
      send_frame(8'hB4, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      rx       = 1'b1;
      word_ack = 1'b0;
      n_cmp++;
      if (word_valid !== 1'b1 || word !== 32'hB4B3B2B1 || overrun !== 1'b0) begin
         n_err++;
         $display("FAIL ovr_ack_reload: valid=%b word=%h ovr=%b want 1 b4b3b2b1 0",
                  word_valid, word, overrun);
      end
      @(negedge clk);
      n_cmp++;
      if (ov_cnt - o0 !== 1) begin
         n_err++;
         $display("FAIL ovr_count: got %0d overrun pulses want 1", ov_cnt - o0);
      end
      ack_word();
      n_cmp++;
      if (word_valid !== 1'b0) begin
         n_err++;
         $display("FAIL ovr_final_ack: word_valid=%b want 0", word_valid);
      end
   endtask

   task automatic test_timeout();
      send_frame(8'h10, 1'b0, 1'b1, 1'b0);
      send_frame(8'h20, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      rx = 1'b1;
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL tmo_start: busy=%b want 1", busy);
      end
      repeat (63) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL tmo_63: busy=%b after 63 idle cycles want 1", busy);
      end
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL tmo_64: busy=%b after 64 idle cycles want 0", busy);
      end
      send_frame(8'h0A, 1'b0, 1'b1, 1'b0);
      send_frame(8'h0B, 1'b0, 1'b1, 1'b0);
      send_frame(8'h0C, 1'b0, 1'b1, 1'b0);
      send_frame(8'h0D, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      rx = 1'b1;
      n_cmp++;
      if (word_valid !== 1'b1 || word !== 32'h0D0C0B0A) begin
         n_err++;
         $display("FAIL tmo_fresh: valid=%b word=%h want 1 0d0c0b0a", word_valid, word);
      end
      ack_word();
   endtask

   task automatic test_reset_mid_frame();
      int b0;
      int f0;
      b0 = bv_cnt;
      f0 = fe_cnt;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         rx = 1'b0;
      end
      @(negedge clk);
      nRst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (word !== 32'h0 || {word_valid, byte_valid, busy} !== 3'b000) begin
         n_err++;
         $display("FAIL midrst_outputs: word=%h flags=%b want 00000000 000",
                  word, {word_valid, byte_valid, busy});
      end
      nRst = 1'b0;
      repeat (12) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL midrst_wait: busy=%b while rx low want 1", busy);
      end
      n_cmp++;
      if (bv_cnt - b0 !== 0 || fe_cnt - f0 !== 0) begin
         n_err++;
         $display("FAIL midrst_false_start: bytes=%0d ferr=%0d want 0 0",
                  bv_cnt - b0, fe_cnt - f0);
      end
      @(negedge clk);
      rx = 1'b1;
      send_frame(8'h77, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      rx = 1'b1;
      n_cmp++;
      if (byte_valid !== 1'b1) begin
         n_err++;
         $display("FAIL midrst_accept: byte_valid=%b want 1", byte_valid);
      end
      @(negedge clk);
      n_cmp++;
      if (bv_cnt - b0 !== 1) begin
         n_err++;
         $display("FAIL midrst_count: bytes=%0d want 1", bv_cnt - b0);
      end
   endtask

   initial begin
      test_reset();
      test_first_byte();
      test_back_to_back();
      test_parity_err();
      test_frame_err();
      test_overrun();
      test_timeout();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
